reg_file_4x16: RTL and testbench

- Four-entry, 16-bit general-purpose register file for the 16-bit MIPS datapath.
- Sits directly upstream of the ALU operand-select multiplexers: the two read ports drive the 16-bit 2:1 and 4:1 operand muxes.
- The write port is driven by the write-back multiplexer output.
- Register 0 is hard-wired to zero, per MIPS convention.

---
 rtl/reg_file_4x16_pkg.sv | 40 ++++
 rtl/reg_file_4x16_reg16_en.sv | 31 +++
 rtl/reg_file_4x16.sv | 45 ++++
 tb/tb_reg_file_4x16.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/reg_file_4x16_pkg.sv
// Shared widths, constants and operand-mux helpers for the 4x16 register file.
package reg_file_4x16_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 2'b00;
  localparam logic [DATA_W-1:0] ZERO16   = 16'h0000;

  // 16-bit 4:1 operand mux
  function automatic logic [DATA_W-1:0] mux4_16(
    input logic [ADDR_W-1:0] sel,
    input logic [DATA_W-1:0] in0,
    input logic [DATA_W-1:0] in1,
    input logic [DATA_W-1:0] in2,
    input logic [DATA_W-1:0] in3
  );
    logic [DATA_W-1:0] out;
    out = in0;
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      2'd3:    out = in3;
      default: out = ZERO16;
    endcase
    return out;
  endfunction

  // 16-bit 2:1 operand mux
  function automatic logic [DATA_W-1:0] mux2_16(
    input logic              sel,
    input logic [DATA_W-1:0] in0,
    input logic [DATA_W-1:0] in1
  );
    return sel ? in1 : in0;
  endfunction

endpackage

// File: rtl/reg_file_4x16_reg16_en.sv
// DATA_W-bit register with synchronous active-high reset and load enable.
module reg16_en
  import reg_file_4x16_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  // Reset wins over load
  always_comb begin
    data_d = data_q;
    if (reset) begin
      data_d = ZERO16;
    end else if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/reg_file_4x16.sv
// Four-entry 16-bit register file, R0 hard-wired to zero, with write-through bypass.
module reg_file_4x16
  import reg_file_4x16_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  logic [NUM_REGS-1:0] load_en;
  logic [DATA_W-1:0]   r1_q;
  logic [DATA_W-1:0]   r2_q;
  logic [DATA_W-1:0]   r3_q;
  logic                wr_active;
  logic                byp1;
  logic                byp2;

  // 2:4 write-address decode gated by RegWrite; slot 0 has no storage
  always_comb begin
    load_en = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      load_en[i] = RegWrite && (WriteReg == ADDR_W'(i));
    end
  end

  reg16_en u_r1 (.clk(clk), .reset(reset), .en(load_en[1]), .d(WriteData), .q(r1_q));
  reg16_en u_r2 (.clk(clk), .reset(reset), .en(load_en[2]), .d(WriteData), .q(r2_q));
  reg16_en u_r3 (.clk(clk), .reset(reset), .en(load_en[3]), .d(WriteData), .q(r3_q));

  // Bypass is blocked during reset so reads never expose discarded write data
  always_comb begin
    wr_active = RegWrite && !reset && (WriteReg != REG_ZERO);
    byp1      = wr_active && (ReadReg1 == WriteReg);
    byp2      = wr_active && (ReadReg2 == WriteReg);
    ReadData1 = mux2_16(byp1, mux4_16(ReadReg1, ZERO16, r1_q, r2_q, r3_q), WriteData);
    ReadData2 = mux2_16(byp2, mux4_16(ReadReg2, ZERO16, r1_q, r2_q, r3_q), WriteData);
  end

endmodule

// File: tb/tb_reg_file_4x16.sv
// Directed self-checking bench for reg_file_4x16.
module tb_reg_file_4x16;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [1:0]  WriteReg;
  logic [15:0] WriteData;
  logic [1:0]  ReadReg1;
  logic [1:0]  ReadReg2;
  logic [15:0] ReadData1;
  logic [15:0] ReadData2;

  int checks;
  int failures;

  reg_file_4x16 dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    RegWrite  = 1'b1;
    WriteReg  = a;
    WriteData = d;
    tick();
    RegWrite  = 1'b0;
    #1;
  endtask

  task automatic rd_both(input string tag, input logic [1:0] a, input logic [15:0] exp);
    ReadReg1 = a;
    ReadReg2 = a;
    #1;
    check_val($sformatf("%s_p1_a%0d", tag, a), ReadData1, exp);
    check_val($sformatf("%s_p2_a%0d", tag, a), ReadData2, exp);
  endtask

  logic [15:0] exp_tab [4];

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    RegWrite  = 1'b0;
    WriteReg  = 2'd0;
    WriteData = 16'h0000;
    ReadReg1  = 2'd0;
    ReadReg2  = 2'd0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    for (int a = 0; a < 4; a++) rd_both("por", 2'(a), 16'h0000);

    // Reset clears preloaded registers
    wr(2'd1, 16'hAAAA);
    wr(2'd2, 16'h5555);
    wr(2'd3, 16'hFFFF);
    rd_both("pre", 2'd1, 16'hAAAA);
    rd_both("pre", 2'd2, 16'h5555);
    rd_both("pre", 2'd3, 16'hFFFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    for (int a = 0; a < 4; a++) rd_both("rst", 2'(a), 16'h0000);

    // Basic write/read
    wr(2'd2, 16'h1234);
    rd_both("basic", 2'd2, 16'h1234);
    rd_both("basic", 2'd1, 16'h0000);
    rd_both("basic", 2'd3, 16'h0000);

    // RegWrite=0 leaves state unchanged, also with X addresses
    WriteReg  = 2'd2;
    WriteData = 16'h9999;
    tick();
    WriteReg  = 2'bxx;
    tick();
    WriteReg  = 2'd0;
    rd_both("nowr", 2'd2, 16'h1234);
    rd_both("nowr", 2'd1, 16'h0000);

    // R0 write ignored, no bypass on R0
    RegWrite  = 1'b1;
    WriteReg  = 2'd0;
    WriteData = 16'hBEEF;
    rd_both("r0_during", 2'd0, 16'h0000);
    tick();
    RegWrite = 1'b0;
    rd_both("r0_after", 2'd0, 16'h0000);

    // Bypass on one port, stored R1 on the other
    wr(2'd3, 16'h0001);
    wr(2'd1, 16'h4321);
    RegWrite  = 1'b1;
    WriteReg  = 2'd3;
    WriteData = 16'hCAFE;
    ReadReg1  = 2'd3;
    ReadReg2  = 2'd1;
    #1;
    check_val("byp_p1", ReadData1, 16'hCAFE);
    check_val("byp_p2_r1", ReadData2, 16'h4321);
    ReadReg2 = 2'd3;
    #1;
    check_val("byp_both_p2", ReadData2, 16'hCAFE);
    tick();
    RegWrite = 1'b0;
    #1;
    check_val("byp_after_p1", ReadData1, 16'hCAFE);
    check_val("byp_after_p2", ReadData2, 16'hCAFE);

    // Reset vs write collision
    reset     = 1'b1;
    RegWrite  = 1'b1;
    WriteReg  = 2'd1;
    WriteData = 16'h7777;
    ReadReg1  = 2'd1;
    ReadReg2  = 2'd3;
    #1;
    check_val("coll_p1_stored", ReadData1, 16'h4321);
    check_val("coll_p2_stored", ReadData2, 16'hCAFE);
    tick();
    reset    = 1'b0;
    RegWrite = 1'b0;
    #1;
    check_val("coll_after_r1", ReadData1, 16'h0000);
    check_val("coll_after_r3", ReadData2, 16'h0000);

    // Dual-port sweep
    wr(2'd1, 16'h0F0F);
    wr(2'd2, 16'hF0F0);
    exp_tab[0] = 16'h0000;
    exp_tab[1] = 16'h0F0F;
    exp_tab[2] = 16'hF0F0;
    exp_tab[3] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ReadReg1 = 2'(i);
        ReadReg2 = 2'(j);
        #1;
        check_val($sformatf("sweep_p1_%0d_%0d", i, j), ReadData1, exp_tab[i]);
        check_val($sformatf("sweep_p2_%0d_%0d", i, j), ReadData2, exp_tab[j]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
